bf_program_loader: RTL and testbench
====================================

// Module: bf_program_loader
// PURPOSE
//  Upstream feeder of the program RAM. Takes a byte stream (UART/host) on a valid/ready
//  handshake, keeps only the 8 Brainfuck opcodes, writes them to consecutive RAM addresses
//  from 0, then appends a 0x00 end marker. Clears the RAM before loading and checks bracket
//  balance. Reports done/error to the sequencer, which then releases the CPU.
// PARAMETERS
//  size      512  RAM depth in bytes. Opcodes go to 0..size-2; size-1 is reserved for the marker.
//  addrSize  9    RAM address width; must satisfy 2**addrSize >= size.
//  DEPTH_W   8    Width of the bracket-depth counter.
// PORTS
//  clk       in   1         clock
//  reset     in   1         synchronous, active-high reset
//  start     in   1         begin a load; sampled only in IDLE
//  in_valid  in   1         input byte valid
//  in_data   in   8         input byte
//  in_ready  out  1         loader accepts in_data this cycle
//  ram_clear out  1         drives the RAM clear input
//  write_rq  out  1         RAM write strobe
//  wr_addr   out  addrSize  RAM write address (addr_in)
//  wr_data   out  8         RAM write data (dataIn)
//  busy      out  1         high from start accept until done
//  done      out  1         one-cycle pulse at end of load
//  error     out  1         load failed; held until next accepted start
//  err_code  out  2         00 none, 01 overflow, 10 stray ']', 11 unclosed '['
//  prog_len  out  addrSize  number of opcodes stored (marker excluded)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; counters 0. Reset mid-load aborts at once, with no
//    write in that cycle. RAM contents are then invalid until the next load.
//  - Every output is registered.
//  - States and transitions:
//      IDLE -start-> CLEAR (1 cyc) -> LOAD -> TERM (1 cyc) -> DRAIN (1 cyc) -> IDLE.
//  - start accept: busy=1. error, err_code, prog_len and depth are zeroed.
//  - CLEAR: ram_clear=1 for exactly one cycle. in_ready=0.
//  - LOAD: in_ready=1 every cycle, one byte per cycle max. Transfer = in_valid & in_ready.
//  - Opcodes: + - < > [ ] . , (0x2B 0x2D 0x3C 0x3E 0x5B 0x5D 0x2E 0x2C).
//  - Opcode transfer at edge N:
//      write_rq=1, wr_addr=prog_len, wr_data=byte during cycle N+1; prog_len increments.
//  - Any other byte is dropped silently, except 0x00 and '!' (0x21), which are terminators.
//  - Bracket depth: '[' increments; ']' decrements.
//      ']' at depth 0 -> err 10, go to TERM.
//      '[' at depth 2**DEPTH_W-1 -> err 11, go to TERM.
//  - Overflow: an opcode arriving when prog_len==size-1 -> err 01, not written, go to TERM.
//  - Terminator: go to TERM. If depth!=0 at that point -> err 11.
//  - TERM: in_ready=0; write_rq=1, wr_addr=prog_len, wr_data=0x00. Written even on error,
//    so the RAM is always terminated.
//  - DRAIN: one cycle so the RAM's staged copy makes the final write readable.
//  - Exit DRAIN: done=1 for 1 cycle, busy=0; error=(err_code!=0).
//  - start while busy: ignored. start and reset together: reset wins.
//  - At most one error is recorded per load: the first one wins.
//  - write_rq and ram_clear are never high in the same cycle.
// STRUCTURE
//  - Package bf_pkg holds:
//      opcode byte localparams (OP_INC .. OP_IN, TERM_NUL, TERM_BANG);
//      err_code localparams;
//      loader state encoding.
//  - One natural sub-module: bf_opcode_classify. Combinational.
//      Input: byte. Outputs: is_op, is_open, is_close, is_term.
//  - The FSM, address counter and depth counter stay in this module.
// TESTING
//  1. reset, start, stream "+[>.<-]" then 0x00 -> RAM[0..6]=opcodes, RAM[7]=0,
//     prog_len=7, done pulse, error=0.
//  2. Stream "a+ b\n-!" -> only '+' and '-' written; RAM[2]=0; prog_len=2.
//  3. Stream "]" -> err_code=10, RAM[0]=0, done.
//     Separately, "[[+]" then 0x00 -> err_code=11, prog_len=4.
//  4. size=8: stream 8 '+' -> 7 written, err_code=01, RAM[7]=0, prog_len=7.
//  5. in_valid toggling every other cycle, plus start pulsed mid-LOAD -> no duplicate or
//     lost bytes, start ignored. ram_clear seen exactly once per load, before the first write.
//  6. reset asserted during LOAD -> next cycle all outputs 0, state IDLE.
//     A new start then loads normally.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared constants for the Brainfuck program loader: opcode bytes, terminators,
// error codes and the loader state encoding.
package bf_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;  // +
  localparam logic [7:0] OP_DEC   = 8'h2D;  // -
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // <
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // >
  localparam logic [7:0] OP_OPEN  = 8'h5B;  // [
  localparam logic [7:0] OP_CLOSE = 8'h5D;  // ]
  localparam logic [7:0] OP_OUT   = 8'h2E;  // .
  localparam logic [7:0] OP_IN    = 8'h2C;  // ,

  localparam logic [7:0] TERM_NUL  = 8'h00;
  localparam logic [7:0] TERM_BANG = 8'h21;

  localparam logic [1:0] ERR_NONE        = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW    = 2'b01;
  localparam logic [1:0] ERR_STRAY_CLOSE = 2'b10;
  localparam logic [1:0] ERR_UNCLOSED    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_TERM,
    ST_DRAIN
  } loader_state_e;

endpackage

// File: rtl/bf_program_loader_if.sv
// Byte-stream, program-RAM write and sequencer status signals of the loader.
// The loader is the slave; the host/sequencer side is the master.
interface bf_program_loader_if #(
  parameter int ADDR_W = 9
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              ram_clear;
  logic              write_rq;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] prog_len;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, ram_clear, write_rq, wr_addr, wr_data,
           busy, done, error, err_code, prog_len
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, ram_clear, write_rq, wr_addr, wr_data,
           busy, done, error, err_code, prog_len
  );
endinterface

// File: rtl/bf_opcode_classify.sv
// Combinational classifier: flags Brainfuck opcodes, loop brackets and
// stream terminators in an input byte.
module bf_opcode_classify
  import bf_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_op_o,
  output logic       is_open_o,
  output logic       is_close_o,
  output logic       is_term_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    is_op_o    = 1'b0;
    is_open_o  = 1'b0;
    is_close_o = 1'b0;
    is_term_o  = 1'b0;
    case (byte_i)
      OP_INC, OP_DEC, OP_LEFT, OP_RIGHT, OP_OUT, OP_IN: is_op_o = 1'b1;
      OP_OPEN: begin
        is_op_o   = 1'b1;
        is_open_o = 1'b1;
      end
      OP_CLOSE: begin
        is_op_o    = 1'b1;
        is_close_o = 1'b1;
      end
      TERM_NUL, TERM_BANG: is_term_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Filters a host byte stream down to Brainfuck opcodes, writes them to program RAM
// from address 0, appends a 0x00 marker and reports bracket/overflow errors.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int size     = 512,
  parameter int addrSize = 9,
  parameter int DEPTH_W  = 8
) (
  input logic               clk,
  input logic               reset,
  bf_program_loader_if.slave bus
);

  localparam logic [addrSize-1:0] LAST_ADDR = addrSize'(size - 1);
  localparam logic [DEPTH_W-1:0]  DEPTH_MAX = '1;

  loader_state_e         state_q;
  logic                  in_ready_q;
  logic                  ram_clear_q;
  logic                  write_rq_q;
  logic [addrSize-1:0]   wr_addr_q;
  logic [7:0]            wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic [1:0]            err_code_q;
  logic [addrSize-1:0]   prog_len_q;
  logic [DEPTH_W-1:0]    depth_q;

  logic is_op, is_open, is_close, is_term;
  logic xfer, store, stop;
  logic [1:0] load_err;

  bf_opcode_classify u_classify (
    .byte_i    (bus.in_data),
    .is_op_o   (is_op),
    .is_open_o (is_open),
    .is_close_o(is_close),
    .is_term_o (is_term)
  );

  // in_ready is only ever high in LOAD, so a transfer implies the LOAD state.
  assign xfer = bus.in_valid & in_ready_q;

  // Per-byte decision: store the opcode, or stop the load (with an error code if any).
  // Overflow is checked before bracket rules, so a full program reports 01.
  always_comb begin
    store    = 1'b0;
    stop     = 1'b0;
    load_err = ERR_NONE;
    if (xfer) begin
      if (is_term) begin
        stop = 1'b1;
        if (depth_q != '0) load_err = ERR_UNCLOSED;
      end else if (is_op) begin
        if (prog_len_q == LAST_ADDR) begin
          stop     = 1'b1;
          load_err = ERR_OVERFLOW;
        end else if (is_close && depth_q == '0) begin
          stop     = 1'b1;
          load_err = ERR_STRAY_CLOSE;
        end else if (is_open && depth_q == DEPTH_MAX) begin
          stop     = 1'b1;
          load_err = ERR_UNCLOSED;
        end else begin
          store = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      ram_clear_q <= 1'b0;
      write_rq_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      prog_len_q  <= '0;
      depth_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      write_rq_q  <= 1'b0;
      ram_clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            prog_len_q  <= '0;
            depth_q     <= '0;
            ram_clear_q <= 1'b1;
            state_q     <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          in_ready_q <= 1'b1;
          state_q    <= ST_LOAD;
        end
        ST_LOAD: begin
          if (store) begin
            write_rq_q <= 1'b1;
            wr_addr_q  <= prog_len_q;
            wr_data_q  <= bus.in_data;
            prog_len_q <= prog_len_q + addrSize'(1);
            if (is_open)  depth_q <= depth_q + DEPTH_W'(1);
            if (is_close) depth_q <= depth_q - DEPTH_W'(1);
          end else if (stop) begin
            // The end marker goes out even on error so the RAM is always terminated.
            in_ready_q <= 1'b0;
            err_code_q <= load_err;
            write_rq_q <= 1'b1;
            wr_addr_q  <= prog_len_q;
            wr_data_q  <= TERM_NUL;
            state_q    <= ST_TERM;
          end
        end
        ST_TERM: state_q <= ST_DRAIN;
        ST_DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          error_q <= (err_code_q != ERR_NONE);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ram_clear = ram_clear_q;
  assign bus.write_rq  = write_rq_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_code_q;
  assign bus.prog_len  = prog_len_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Self-checking bench for bf_program_loader: directed vector table, randomized
// streams against a behavioural model, and a reset-during-load sequence.
module tb_bf_program_loader;

  localparam int SIZE    = 8;
  localparam int ADDR_W  = 3;
  localparam int DEPTH_W = 2;
  localparam int DMAX    = (1 << DEPTH_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bf_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  bf_program_loader #(
    .size    (SIZE),
    .addrSize(ADDR_W),
    .DEPTH_W (DEPTH_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Program RAM model plus bus observers, sampled mid-cycle.
  logic [7:0] mem [SIZE];
  int clr_cnt, wr_cnt, done_cnt, early_wr, overlap_cnt;

  always @(negedge clk) begin
    if (bus.ram_clear && bus.write_rq) overlap_cnt++;
    if (bus.ram_clear) begin
      clr_cnt++;
      for (int i = 0; i < SIZE; i++) mem[i] = 8'h00;
    end
    if (bus.write_rq) begin
      if (clr_cnt == 0) early_wr++;
      mem[bus.wr_addr] = bus.wr_data;
      wr_cnt++;
    end
    if (bus.done) done_cnt++;
  end

  logic [21:0] outs;
  assign outs = {bus.in_ready, bus.ram_clear, bus.write_rq, bus.wr_addr, bus.wr_data,
                 bus.busy, bus.done, bus.error, bus.err_code, bus.prog_len};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_bf(input logic [7:0] b);
    string ops;
    ops = "+-<>[].,";
    for (int k = 0; k < ops.len(); k++)
      if (b == ops[k]) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural model: walks the stream with the loader's rules.
  function automatic void model(input logic [7:0] q[$], output logic [7:0] r[SIZE],
                                output int len, output logic [1:0] ec);
    int depth;
    depth = 0;
    len   = 0;
    ec    = 2'b00;
    for (int i = 0; i < SIZE; i++) r[i] = 8'h00;
    foreach (q[i]) begin
      logic [7:0] b;
      b = q[i];
      if (b == 8'h00 || b == 8'h21) begin
        if (depth != 0) ec = 2'b11;
        break;
      end
      if (!is_bf(b)) continue;
      if (len == SIZE - 1) begin ec = 2'b01; break; end
      if (b == 8'h5D && depth == 0) begin ec = 2'b10; break; end
      if (b == 8'h5B && depth == DMAX) begin ec = 2'b11; break; end
      if (b == 8'h5B) depth++;
      if (b == 8'h5D) depth--;
      r[len] = b;
      len++;
    end
  endfunction

  task automatic run_load(input logic [7:0] q[$], input bit gap, input bit poke);
    int idx, cyc;
    bit take;
    @(posedge clk);
    clr_cnt = 0; wr_cnt = 0; done_cnt = 0; early_wr = 0; overlap_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    idx = 0; cyc = 0; take = 1'b0;
    while (done_cnt == 0 && cyc < 100) begin
      if (take) idx++;
      bus.in_valid = (idx < q.size()) && (!gap || cyc[0]);
      bus.in_data  = (idx < q.size()) ? q[idx] : 8'h00;
      take         = bus.in_valid && bus.in_ready;
      if (poke) bus.start = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic verify(input string tag, input logic [7:0] er[SIZE], input int elen,
                        input logic [1:0] eerr);
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/busy"}, bus.busy, 0);
    check({tag, "/err_code"}, bus.err_code, eerr);
    check({tag, "/error"}, bus.error, eerr != 2'b00);
    check({tag, "/prog_len"}, bus.prog_len, elen);
    check({tag, "/clears"}, clr_cnt, 1);
    check({tag, "/write_before_clear"}, early_wr, 0);
    check({tag, "/clear_write_overlap"}, overlap_cnt, 0);
    check({tag, "/writes"}, wr_cnt, elen + 1);
    for (int i = 0; i < SIZE; i++)
      check($sformatf("%s/ram[%0d]", tag, i), mem[i], er[i]);
  endtask

  typedef struct {
    string      body;
    logic [7:0] term;
    bit         gap;
    bit         poke;
    string      exp_prog;
    logic [1:0] exp_err;
  } vec_t;

  function automatic vec_t mk(input string b, input logic [7:0] t, input bit g, input bit p,
                              input string e, input logic [1:0] ec);
    vec_t v;
    v.body = b; v.term = t; v.gap = g; v.poke = p; v.exp_prog = e; v.exp_err = ec;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    logic [7:0] q[$];
    logic [7:0] er[SIZE];
    string      s;
    s = v.body;
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    q.push_back(v.term);
    s = v.exp_prog;
    for (int i = 0; i < SIZE; i++) er[i] = (i < s.len()) ? s[i] : 8'h00;
    run_load(q, v.gap, v.poke);
    verify(tag, er, s.len(), v.exp_err);
  endtask

  initial begin
    vec_t vecs[$];
    vecs.push_back(mk("+[>.<-]",  8'h00, 0, 0, "+[>.<-]", 2'b00));
    vecs.push_back(mk("a+ b\n-",  8'h21, 0, 0, "+-",      2'b00));
    vecs.push_back(mk("]",        8'h00, 0, 0, "",        2'b10));
    vecs.push_back(mk("[[+]",     8'h00, 0, 0, "[[+]",    2'b11));
    vecs.push_back(mk("++++++++", 8'h00, 0, 0, "+++++++", 2'b01));
    vecs.push_back(mk("+x>y-z<",  8'h00, 1, 1, "+>-<",    2'b00));
    vecs.push_back(mk("[[[[",     8'h00, 0, 0, "[[[",     2'b11));
    vecs.push_back(mk("",         8'h21, 1, 0, "",        2'b00));
    vecs.push_back(mk("[]]",      8'h00, 0, 0, "[]",      2'b10));

    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of a load, then a clean reload.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h2B;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("reset_mid_load_outputs", outs, 0);
    reset = 1'b0;
    run_vec("after_reset", vecs[0]);

    // Randomized streams against the model.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] q[$];
      logic [7:0] er[SIZE];
      int         elen;
      logic [1:0] eerr;
      string      alpha;
      int         n;
      alpha = "+-<>[].,[]][";
      n = $urandom_range(0, 12);
      for (int k = 0; k < n; k++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 12)       q.push_back(alpha[r]);
        else if (r < 18)  q.push_back(8'h61 + 8'(r - 12));
        else if (r == 18) q.push_back(8'h21);
        else              q.push_back(8'h00);
      end
      q.push_back(8'h00);
      model(q, er, elen, eerr);
      run_load(q, 1'($urandom_range(0, 1)), 1'b0);
      verify($sformatf("rand%0d", t), er, elen, eerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
